// File: rtl/var_delay_pkg.sv
// Shared types, reset constants and the delay clamp for the var_delay block.
// Optional feature macro: VAR_DELAY_BYPASS_EN (a delay of 0 becomes a combinational bypass).
package var_delay_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

`ifdef VAR_DELAY_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    localparam state_t RST_STATE  = FILL;
    localparam logic   RST_VALID  = 1'b0;
    localparam logic   RST_PRIMED = 1'b0;

    // A delay of zero only makes sense when the bypass path exists.
    function automatic int clamp_cycle(input int req, input int max_c);
        int res;
        if (req <= 32'sd0) begin
            res = BYPASS_EN ? 32'sd0 : 32'sd1;
        end else if (req > max_c) begin
            res = max_c;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/var_delay_ctrl.sv
// Delay configuration register, fill counter and FILL/RUN state machine for var_delay.
// Optional feature macro: VAR_DELAY_BYPASS_EN (via the package clamp).
module var_delay_ctrl
    import var_delay_pkg::*;
#(
    parameter int max_cycle     = 8,
    parameter int default_cycle = 1,
    parameter int cw            = $clog2(max_cycle + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic          cfg_we,
    input  logic [cw-1:0] cfg_cycle,
    output logic [cw-1:0] cfg_cycle_q,
    output logic          primed
);

    state_t        state_r;
    state_t        state_s;
    logic [cw-1:0] count_r;
    logic [cw-1:0] count_s;
    logic [cw-1:0] count_inc_s;
    logic [cw-1:0] cfg_r;
    logic [cw-1:0] cfg_s;
    logic          primed_r;

    // Next-state logic: restart on flush/cfg, otherwise count advancing edges until primed.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        cfg_s       = cfg_r;
        count_inc_s = count_r + cw'(1);
        if (cfg_we || flush) begin
            if (cfg_we) begin
                cfg_s = cw'(clamp_cycle(int'(cfg_cycle), max_cycle));
            end else begin
                cfg_s = cfg_r;
            end
            count_s = '0;
            // A zero delay (bypass only) has nothing to fill.
            state_s = (cfg_s == '0) ? RUN : FILL;
        end else if (en) begin
            case (state_r)
                FILL: begin
                    if (count_inc_s == cfg_r) begin
                        state_s = RUN;
                    end else begin
                        count_s = count_inc_s;
                    end
                end
                RUN:     state_s = RUN;
                default: state_s = FILL;
            endcase
        end else begin
            state_s = state_r;
            count_s = count_r;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RST_STATE;
            count_r  <= '0;
            cfg_r    <= cw'(default_cycle);
            primed_r <= RST_PRIMED;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            cfg_r    <= cfg_s;
            primed_r <= (state_s == RUN);
        end
    end

    assign cfg_cycle_q = cfg_r;
    assign primed      = primed_r;

endmodule

// File: rtl/var_delay.sv
// Multi-lane runtime-configurable delay line with valid tracking, stall and flush.
// Optional feature macro: VAR_DELAY_BYPASS_EN (delay 0 passes bus_in straight through).
module var_delay
    import var_delay_pkg::*;
#(
    parameter int data_size     = 16,
    parameter int size          = 1,
    parameter int max_cycle     = 8,
    parameter int default_cycle = 1,
    parameter int cw            = $clog2(max_cycle + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic [data_size*size-1:0] bus_in,
    input  logic                      cfg_we,
    input  logic [cw-1:0]             cfg_cycle,
    input  logic                      flush,
    output logic [data_size*size-1:0] bus_out,
    output logic                      out_valid,
    output logic                      primed,
    output logic [cw-1:0]             cfg_cycle_q
);

    localparam int BW = data_size * size;

    logic [BW-1:0]        data_r [max_cycle];
    logic [max_cycle-1:0] valid_r;
    logic [cw-1:0]        cfg_q_s;
    logic [BW-1:0]        tap_data_s;
    logic                 tap_valid_s;

    var_delay_ctrl #(
        .max_cycle    (max_cycle),
        .default_cycle(default_cycle),
        .cw           (cw)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .cfg_we     (cfg_we),
        .cfg_cycle  (cfg_cycle),
        .cfg_cycle_q(cfg_q_s),
        .primed     (primed)
    );

    // Shift storage; a restart clears valids but keeps data and drops the incoming sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < max_cycle; i++) begin
                data_r[i]  <= '0;
                valid_r[i] <= RST_VALID;
            end
        end else if (flush || cfg_we) begin
            valid_r <= '0;
        end else if (en) begin
            data_r[0]  <= bus_in;
            valid_r[0] <= in_valid;
            for (int i = 1; i < max_cycle; i++) begin
                data_r[i]  <= data_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Output tap select: stage cfg_cycle_q-1, driven only by registers.
    always_comb begin
        tap_data_s  = '0;
        tap_valid_s = 1'b0;
        for (int i = 0; i < max_cycle; i++) begin
            tap_data_s  = (cfg_q_s == cw'(i + 1)) ? data_r[i]  : tap_data_s;
            tap_valid_s = (cfg_q_s == cw'(i + 1)) ? valid_r[i] : tap_valid_s;
        end
    end

`ifdef VAR_DELAY_BYPASS_EN
    assign bus_out   = (cfg_q_s == '0) ? bus_in : tap_data_s;
    assign out_valid = (cfg_q_s == '0) ? (in_valid & en) : tap_valid_s;
`else
    assign bus_out   = tap_data_s;
    assign out_valid = tap_valid_s;
`endif

    assign cfg_cycle_q = cfg_q_s;

endmodule

// File: tb/tb_var_delay.sv
// Self-checking bench for var_delay: randomized stimulus against a queue-based reference model.
module tb_var_delay;

    localparam int DS   = 16;
    localparam int NL   = 2;
    localparam int W    = DS * NL;
    localparam int MAXC = 8;
    localparam int DEFC = 1;
    localparam int CW   = $clog2(MAXC + 1);
`ifdef VAR_DELAY_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          in_valid;
    logic [W-1:0]  bus_in;
    logic          cfg_we;
    logic [CW-1:0] cfg_cycle;
    logic          flush;
    logic [W-1:0]  bus_out;
    logic          out_valid;
    logic          primed;
    logic [CW-1:0] cfg_cycle_q;

    int pass_cnt = 0;
    int total    = 0;

    // Model: captured samples newest-first, delay in effect, advancing edges since restart.
    logic [W-1:0] hist_d[$];
    logic         hist_v[$];
    int           cfg_m;
    int           edges_m;

    var_delay #(
        .data_size(DS), .size(NL), .max_cycle(MAXC), .default_cycle(DEFC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .bus_in(bus_in),
        .cfg_we(cfg_we), .cfg_cycle(cfg_cycle), .flush(flush), .bus_out(bus_out),
        .out_valid(out_valid), .primed(primed), .cfg_cycle_q(cfg_cycle_q)
    );

    always #5 clk = ~clk;

    function automatic int clamp_m(input int c);
        if (c == 0) return BYP ? 0 : 1;
        if (c > MAXC) return MAXC;
        return c;
    endfunction

    function automatic void model_reset();
        hist_d.delete();
        hist_v.delete();
        cfg_m   = DEFC;
        edges_m = 0;
    endfunction

    function automatic logic [W-1:0] exp_data();
        if (cfg_m == 0) return bus_in;
        if (cfg_m - 1 < hist_d.size()) return hist_d[cfg_m-1];
        return '0;
    endfunction

    function automatic logic exp_valid();
        if (cfg_m == 0) return in_valid & en;
        if (cfg_m - 1 < hist_v.size()) return hist_v[cfg_m-1];
        return 1'b0;
    endfunction

    function automatic logic exp_primed();
        return (edges_m >= cfg_m);
    endfunction

    task automatic step(input logic e, input logic v, input logic [W-1:0] d,
                        input logic fl, input logic cwe, input logic [CW-1:0] c);
        en = e; in_valid = v; bus_in = d; flush = fl; cfg_we = cwe; cfg_cycle = c;
        @(posedge clk);
        if (fl || cwe) begin
            if (cwe) cfg_m = clamp_m(int'(c));
            for (int i = 0; i < hist_v.size(); i++) hist_v[i] = 1'b0;
            edges_m = 0;
        end else if (e) begin
            hist_d.push_front(d);
            hist_v.push_front(v);
            if (hist_d.size() > MAXC) begin
                void'(hist_d.pop_back());
                void'(hist_v.pop_back());
            end
            if (edges_m < 1000) edges_m++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0; in_valid = 1'b0; bus_in = '0; flush = 1'b0; cfg_we = 1'b0; cfg_cycle = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++; if (bus_out !== '0) $display("FAIL reset_bus_out got=%h exp=0", bus_out); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (primed !== 1'b0) $display("FAIL reset_primed got=%b exp=0", primed); else pass_cnt++;
        total++; if (cfg_cycle_q !== CW'(DEFC)) $display("FAIL reset_cfg got=%0d exp=%0d", cfg_cycle_q, DEFC); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_default_stream();
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b1, {DS'(k), DS'(k)}, 1'b0, 1'b0, '0);
            total++; if (bus_out !== {DS'(k), DS'(k)}) $display("FAIL dflt_data k=%0d got=%h exp=%h", k, bus_out, {DS'(k), DS'(k)}); else pass_cnt++;
            total++; if (out_valid !== 1'b1) $display("FAIL dflt_valid k=%0d got=%b exp=1", k, out_valid); else pass_cnt++;
            total++; if (primed !== 1'b1) $display("FAIL dflt_primed k=%0d got=%b exp=1", k, primed); else pass_cnt++;
        end
    endtask

    task automatic test_cfg4();
        logic [W-1:0] smp [3];
        smp[0] = 32'hAAAA_0A0A; smp[1] = 32'hBBBB_0B0B; smp[2] = 32'hCCCC_0C0C;
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, CW'(4));
        total++; if (cfg_cycle_q !== CW'(4)) $display("FAIL cfg4_q got=%0d exp=4", cfg_cycle_q); else pass_cnt++;
        total++; if (primed !== 1'b0) $display("FAIL cfg4_primed_load got=%b exp=0", primed); else pass_cnt++;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, k < 3, (k < 3) ? smp[k] : W'($urandom), 1'b0, 1'b0, '0);
            total++; if (out_valid !== exp_valid()) $display("FAIL cfg4_valid k=%0d got=%b exp=%b", k, out_valid, exp_valid()); else pass_cnt++;
            total++; if (primed !== (k >= 3)) $display("FAIL cfg4_primed k=%0d got=%b exp=%b", k, primed, k >= 3); else pass_cnt++;
            if (k >= 3 && k <= 5) begin
                total++; if (bus_out !== smp[k-3] || out_valid !== 1'b1) $display("FAIL cfg4_data k=%0d got=%h/%b exp=%h/1", k, bus_out, out_valid, smp[k-3]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] x;
        x = 32'h5A5A_1234;
        step(1'b1, 1'b1, x, 1'b0, 1'b0, '0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'($urandom), W'($urandom), 1'b0, 1'b0, '0);
            total++; if (bus_out !== exp_data() || out_valid !== exp_valid() || primed !== exp_primed())
                $display("FAIL stall_hold k=%0d got=%h/%b/%b exp=%h/%b/%b", k, bus_out, out_valid, primed, exp_data(), exp_valid(), exp_primed()); else pass_cnt++;
        end
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, W'($urandom), 1'b0, 1'b0, '0);
            if (k < 3) begin
                total++; if (out_valid !== 1'b0) $display("FAIL stall_early k=%0d got=%b exp=0", k, out_valid); else pass_cnt++;
            end else begin
                total++; if (bus_out !== x || out_valid !== 1'b1) $display("FAIL stall_emerge got=%h/%b exp=%h/1", bus_out, out_valid, x); else pass_cnt++;
            end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] drop;
        drop = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, W'($urandom), 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, drop, 1'b1, 1'b0, '0);
        total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (primed !== 1'b0) $display("FAIL flush_primed got=%b exp=0", primed); else pass_cnt++;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, k >= 2, W'($urandom), 1'b0, 1'b0, '0);
            total++; if (out_valid !== exp_valid() || primed !== exp_primed())
                $display("FAIL flush_after k=%0d got=%b/%b exp=%b/%b", k, out_valid, primed, exp_valid(), exp_primed()); else pass_cnt++;
            total++; if (out_valid === 1'b1 && bus_out === drop) $display("FAIL flush_dropped k=%0d got=%h exp=not %h", k, bus_out, drop); else pass_cnt++;
        end
    endtask

    task automatic test_clamp();
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, CW'(15));
        total++; if (cfg_cycle_q !== CW'(MAXC)) $display("FAIL clamp_hi got=%0d exp=%0d", cfg_cycle_q, MAXC); else pass_cnt++;
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, CW'(0));
        total++; if (cfg_cycle_q !== CW'(BYP ? 0 : 1)) $display("FAIL clamp_lo got=%0d exp=%0d", cfg_cycle_q, BYP ? 0 : 1); else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, W'($urandom), 1'b0, 1'b0, '0);
            in_valid = 1'($urandom); bus_in = W'($urandom);
            #1;
            total++; if (bus_out !== exp_data() || out_valid !== exp_valid() || primed !== exp_primed())
                $display("FAIL clamp_lo_out k=%0d got=%h/%b/%b exp=%h/%b/%b", k, bus_out, out_valid, primed, exp_data(), exp_valid(), exp_primed()); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), W'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0, CW'($urandom_range(0, 15)));
            total++; if (bus_out !== exp_data() || out_valid !== exp_valid() || primed !== exp_primed() || cfg_cycle_q !== CW'(cfg_m))
                $display("FAIL rand k=%0d got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", k, bus_out, out_valid, primed, cfg_cycle_q,
                         exp_data(), exp_valid(), exp_primed(), cfg_m); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, CW'(4));
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, W'($urandom) | 32'h1, 1'b0, 1'b0, '0);
        total++; if (out_valid !== 1'b1 || primed !== 1'b1) $display("FAIL mid_pre got=%b/%b exp=1/1", out_valid, primed); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (bus_out !== '0) $display("FAIL mid_bus_out got=%h exp=0", bus_out); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total++; if (primed !== 1'b0) $display("FAIL mid_primed got=%b exp=0", primed); else pass_cnt++;
        total++; if (cfg_cycle_q !== CW'(DEFC)) $display("FAIL mid_cfg got=%0d exp=%0d", cfg_cycle_q, DEFC); else pass_cnt++;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, W'($urandom), 1'b0, 1'b0, '0);
            total++; if (bus_out !== exp_data() || out_valid !== exp_valid() || primed !== exp_primed())
                $display("FAIL mid_after k=%0d got=%h/%b/%b exp=%h/%b/%b", k, bus_out, out_valid, primed, exp_data(), exp_valid(), exp_primed()); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_cfg4();
        test_stall();
        test_flush();
        test_clamp();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/var_delay.md
Name: var_delay

Overview:
- Multi-lane, runtime-configurable delay line with per-sample valid tracking, stall (advance enable) and flush.
- Successor to the fixed-cycle register delay used to align datapaths in the neuron/accumulator pipelines.
- Delay is a register value, up to max_cycle, loaded at runtime; a fill FSM reports when the pipe is primed.

Parameters:
- data_size, 16, bits per lane
- size, 1, number of lanes; bus width = data_size*size
- max_cycle, 8, maximum delay in cycles (storage depth); must be >= 1
- default_cycle, 1, delay after reset; 1..max_cycle
- cw, $clog2(max_cycle+1), width of the delay configuration field

Ports:
- clk, in, 1, clock; all state updates on the posedge
- rst_n, in, 1, asynchronous active-low reset
- en, in, 1, advance enable; 0 = stall, all state held
- in_valid, in, 1, bus_in carries a sample
- bus_in, in, data_size*size, input data (all lanes)
- cfg_we, in, 1, load cfg_cycle and restart fill
- cfg_cycle, in, cw, requested delay
- flush, in, 1, synchronous clear of the contents' valid bits
- bus_out, out, data_size*size, delayed data
- out_valid, out, 1, bus_out carries a valid delayed sample
- primed, out, 1, pipe filled to current delay since last reset/flush/cfg
- cfg_cycle_q, out, cw, delay currently in effect (after clamping)

Behaviour:
- Reset (rst_n low, async): all stage data = 0, valid bits = 0, cfg_cycle_q = default_cycle, FSM = FILL, fill count = 0. Outputs: bus_out = 0, out_valid = 0, primed = 0.
- Storage: stages 0..max_cycle-1, each holding data plus a valid bit. Stage 0 is the newest.
- Advancing edge (en=1, no flush, no cfg_we):
  - stage[0] <= {bus_in, in_valid}
  - stage[i] <= stage[i-1]
- Output taps stage[cfg_cycle_q-1]: bus_out = its data, out_valid = its valid. Outputs come straight from registers, with no combinational path from the inputs.
- Latency: a sample captured at advancing edge t is on bus_out after cfg_cycle_q-1 further advancing edges. This equals cfg_cycle_q clocks when en is held high.
- Stall (en=0): stages, counter, FSM and outputs hold. bus_in and in_valid are ignored.
- flush=1 (regardless of en):
  - all valid bits cleared; data retained
  - FSM -> FILL, count = 0
  - input on that edge dropped
- cfg_wean=1 (regardless of en): same effect as flush, and cfg_cycle_q loads clamp(cfg_cycle).
  - Clamp: 0 -> 1; values above max_cycle -> max_cycle.
  - cfg_we together with flush: a single flush occurs and the config loads.
- FSM:
  - FILL: each advancing edge increments count. When count+1 == cfg_cycle_q on an advancing edge, go to RUN and set primed=1 on the same edge.
  - RUN: primed=1. Stays in RUN until flush, cfg_we or reset.
- primed is independent of in_valid: it means the timing is aligned, not that the data is valid.
- Lanes share valid, enable and delay. No per-lane behaviour.
- Reset asserted mid-operation: immediate return to reset values. There is no partial state.

Optional Feature:
- Macro: VAR_DELAY_BYPASS_EN.
- Defined:
  - cfg_cycle = 0 is legal and loads cfg_cycle_q = 0.
  - bus_out = bus_in and out_valid = in_valid & en, combinationally.
  - primed = 1 one edge after the load. The FSM goes straight to RUN.
  - Storage keeps shifting but is unobserved.
- Not defined: 0 is clamped to 1, and no combinational path exists.

Decomposition:
- Package var_delay_pkg:
  - state enum {FILL, RUN}
  - clamp_cycle function (max_cycle and bypass aware)
  - reset constants
- One natural sub-module, var_delay_ctrl: cfg register, clamp, fill counter, FSM, primed.
- The shift storage and output mux stay in the top level.

Test Plan:
- Reset, default_cycle=1, size=2, data_size=16, en=1, stream 0x0001..0x0005 valid:
  - each value appears one cycle later, out_valid=1
  - primed rises at the first edge
- cfg_we with cfg_cycle=4, stream A,B,C:
  - out_valid=0 for 3 cycles, then A,B,C on consecutive cycles
  - primed rises at the 4th advancing edge
  - cfg_cycle_q=4
- cfg_cycle=4, sample X, en=0 for 5 cycles, then en=1:
  - X emerges after exactly 3 more advancing edges
  - outputs frozen during the stall
- In RUN with 3 valid samples in flight, pulse flush:
  - out_valid=0 until new data passes
  - primed=0, then primed=1 after cfg_cycle_q advancing edges
  - the sample on the flush edge is never emitted
- cfg_cycle=0 and cfg_cycle=15 with max_cycle=8:
  - cfg_cycle_q = 1 and 8
  - with VAR_DELAY_BYPASS_EN, 0 yields same-cycle bus_out = bus_in
- rst_n low mid-stream with cfg=4 and 4 valid in flight:
  - bus_out=0, out_valid=0, primed=0 immediately
  - cfg_cycle_q=default_cycle
